// File: rtl/dm_pkg.sv
// Shared definitions for the data memory responder.
//   - Access size encodings as carried on req_size.
//   - FSM state encoding used by the top module.
//   - Captured request record.
//   - clog2() helper, used to derive the word-index width from DEPTH_WORDS.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // One request as sampled on the accept edge.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        is_unsigned;
  } req_t;

  // Number of bits needed to index n entries (n >= 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane steering for little-endian sub-word accesses.
// Ports:
//   addr_lo_i      byte offset within the word (addr[1:0])
//   size_i         access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   is_unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   rdata_i        word currently stored at the addressed index
//   wdata_i        store data, right-justified
//   load_val_o     selected lane, extended to 32 bits
//   store_word_o   rdata_i with only the addressed lane(s) replaced
//   misalign_o     half on an odd address, or word not on a 4-byte boundary
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        is_unsigned_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_val_o,
  output logic [31:0] store_word_o,
  output logic        misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sext_bit;

  assign byte_v = rdata_i[{addr_lo_i, 3'b000} +: 8];
  // Half lanes sit at offsets 0 and 2; addr[0] is caught by misalign_o.
  assign half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    load_val_o   = rdata_i;
    store_word_o = rdata_i;
    misalign_o   = 1'b0;
    sext_bit     = 1'b0;
    unique case (size_i)
      SZ_BYTE: begin
        sext_bit   = ~is_unsigned_i & byte_v[7];
        load_val_o = {{24{sext_bit}}, byte_v};
        store_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        sext_bit   = ~is_unsigned_i & half_v[15];
        load_val_o = {{16{sext_bit}}, half_v};
        if (addr_lo_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else              store_word_o[15:0]  = wdata_i[15:0];
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD: begin
        store_word_o = wdata_i;
        misalign_o   = (addr_lo_i != 2'b00);
      end
      default: begin
        // Illegal size is flagged by the caller; outputs keep defaults.
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Word-organised data memory answering load/store requests from the datapath.
// Byte/half/word little-endian accesses, optional sign extension and a
// programmable number of wait states between accept and access.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   req_valid / req_ready    request handshake
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_wdata                store data, right-justified
//   req_size                 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned             zero-extend loads when 1
//   rsp_valid / rsp_ready    response handshake
//   rsp_rdata                load result; 0 for stores and errors
//   rsp_err                  access rejected
module data_memory_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W     = clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  req_t        cap_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  req_t              req_in;
  req_t              acc;
  logic [IDX_W-1:0]  acc_idx;
  logic [31:0]       acc_word;
  logic              out_of_range;
  logic              misalign;
  logic              acc_err;
  logic              do_access;
  logic [31:0]       load_val;
  logic [31:0]       store_word;
  logic [31:0]       rsp_rdata_d;
  logic              rsp_err_d;

  assign req_in = '{we:          req_we,
                    addr:        req_addr,
                    wdata:       req_wdata,
                    size:        req_size,
                    is_unsigned: req_unsigned};

  // With zero wait states the access happens on the accept edge itself, so
  // it must use the live request rather than the captured copy.
  assign acc = (state_q == IDLE) ? req_in : cap_q;

  assign acc_idx      = acc.addr[IDX_W+1:2];
  assign acc_word     = mem_q[acc_idx];
  // Upper address bits are checked, not aliased onto the array.
  assign out_of_range = |(acc.addr >> (IDX_W + 2));

  dm_lane_align u_lane_align (
    .addr_lo_i     (acc.addr[1:0]),
    .size_i        (acc.size),
    .is_unsigned_i (acc.is_unsigned),
    .rdata_i       (acc_word),
    .wdata_i       (acc.wdata),
    .load_val_o    (load_val),
    .store_word_o  (store_word),
    .misalign_o    (misalign)
  );

  assign acc_err     = (acc.size == SZ_ILL) | misalign | out_of_range;
  assign rsp_err_d   = acc_err;
  assign rsp_rdata_d = (acc_err || acc.we) ? 32'd0 : load_val;

  assign do_access = ((state_q == IDLE) && req_valid && (WAIT_STATES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd0));

  // Ready is gated by rst so it is low for the whole reset interval, even
  // before the first reset edge has put the FSM in IDLE.
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // NOTE: the array is reset because its power-up contents are defined
  // (word i holds i); this makes it flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem_q[i] <= 32'(i);
      end
    end else if (do_access && acc.we && !acc_err) begin
      mem_q[acc_idx] <= store_word;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cap_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            cap_q <= req_in;
            if (WAIT_STATES > 0) begin
              state_q <= WAIT;
              cnt_q   <= WAIT_INIT;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_rdata_d;
              rsp_err_q   <= rsp_err_d;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (DEPTH_WORDS=256, WAIT_STATES=2).
// Stimulus pushes the hand-computed response into exp_q when it issues a
// request; the monitor pops and compares on every response handshake.
module tb_data_memory_responder;

  localparam int WS = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  data_memory_responder #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (WS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: compares every response taken by the consumer.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h err %0d with nothing expected",
                   rsp_rdata, rsp_err);
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_wdata    = wdata;
    req_size     = size;
    req_unsigned = uns;
  endtask

  // Called right after a posedge; returns right after the accept posedge.
  task automatic wait_accept(output logic ok);
    int n;
    n  = 0;
    ok = 1'b1;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        timeout("req_accept");
        req_valid = 1'b0;
        ok = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        timeout("rsp_drain");
        exp_q.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Full transaction: issue, check latency, wait for the scoreboard to drain.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err);
    logic ok;
    int   lat;
    exp_t e;
    drive(we, addr, wdata, size, uns);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    wait_accept(ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    // Scramble the request bus; the DUT must use what it captured.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'h5A5A_5A5A;
    req_size  = 2'b11;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(WS + 1));
    wait_drain();
  endtask

  // Entered right after a posedge; leaves right after a posedge in IDLE.
  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_rsp_rdata", rsp_rdata, 32'd0);
    check("post_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : stimulus
    logic ok;
    int   n;
    exp_t e;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;
    @(posedge clk);
    #1;
    reset_dut();

    // Word 0x10 is index 4 -> 4.
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'h0000_0004, 1'b0);

    // Byte store into lane 1 of index 8 (initially 8).
    do_req(1'b1, 32'h21, 32'h0000_00AB, 2'b00, 1'b0, 32'd0, 1'b0);
    do_req(1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h0000_AB08, 1'b0);
    do_req(1'b0, 32'h21, 32'd0, 2'b00, 1'b0, 32'hFFFF_FFAB, 1'b0);
    do_req(1'b0, 32'h21, 32'd0, 2'b00, 1'b1, 32'h0000_00AB, 1'b0);
    do_req(1'b0, 32'h23, 32'd0, 2'b00, 1'b0, 32'h0000_0000, 1'b0);

    // Fresh memory, then half store into the upper lane of index 8.
    reset_dut();
    do_req(1'b1, 32'h22, 32'h0000_8001, 2'b01, 1'b0, 32'd0, 1'b0);
    do_req(1'b0, 32'h22, 32'd0, 2'b01, 1'b0, 32'hFFFF_8001, 1'b0);
    do_req(1'b0, 32'h22, 32'd0, 2'b01, 1'b1, 32'h0000_8001, 1'b0);
    do_req(1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h8001_0008, 1'b0);

    // Error cases: misaligned word, out-of-range store, illegal size, odd half.
    do_req(1'b0, 32'h06,  32'd0,        2'b10, 1'b0, 32'd0, 1'b1);
    do_req(1'b1, 32'h400, 32'h1234_5678, 2'b10, 1'b0, 32'd0, 1'b1);
    do_req(1'b0, 32'h04,  32'd0,        2'b11, 1'b0, 32'd0, 1'b1);
    do_req(1'b0, 32'h21,  32'd0,        2'b01, 1'b0, 32'd0, 1'b1);
    do_req(1'b0, 32'h04,  32'd0,        2'b10, 1'b0, 32'h0000_0001, 1'b0);
    // The rejected store to 0x400 must not alias onto index 0.
    do_req(1'b0, 32'h00,  32'd0,        2'b10, 1'b0, 32'h0000_0000, 1'b0);
    do_req(1'b0, 32'h3FC, 32'd0,        2'b10, 1'b0, 32'h0000_00FF, 1'b0);

    // Back-pressure: response held for 5 cycles with a new request waiting.
    rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
    e.rdata = 32'h0000_0004;
    e.err   = 1'b0;
    exp_q.push_back(e);
    wait_accept(ok);
    drive(1'b0, 32'h04, 32'd0, 2'b10, 1'b0);
    e.rdata = 32'h0000_0001;
    exp_q.push_back(e);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, 32'h0000_0004);
      check("stall_rsp_err", 32'(rsp_err), 32'd0);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("after_hs_req_ready", 32'(req_ready), 32'd1);
    check("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_drain();

    // Reset while a word store is in WAIT: store discarded, memory reinitialised.
    drive(1'b1, 32'h08, 32'hDEAD_BEEF, 2'b10, 1'b0);
    wait_accept(ok);
    reset_dut();
    do_req(1'b0, 32'h08, 32'd0, 2'b10, 1'b0, 32'h0000_0002, 1'b0);

    repeat (5) @(posedge clk);
    check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Word-organised data memory that answers load and store requests issued by the register-file/datapath side.
- Uses a valid/ready request channel and a valid/ready response channel.
- Supports byte, half-word and word accesses, little-endian, with optional sign extension and configurable wait states.
- Sits between the datapath's memory-address/store-data outputs and its load-data write-back input.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two.
- WAIT_STATES, 2: extra cycles inserted between request acceptance and the memory access (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high; clock clk
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  access rejected (misaligned, out of range, or illegal size)

Behaviour:
- Reset values:
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while rst is high.
  - Memory word i is set to i for every word.
  - FSM goes to IDLE with its wait counter at 0.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid&req_ready at a rising edge, and capture we, addr, wdata, size and unsigned.
  - If WAIT_STATES>0, go to WAIT with counter=WAIT_STATES-1.
  - Otherwise perform the access on the accept edge and go to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle.
  - On the edge where counter==0, perform the access and go to RESP.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accept cycle.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err stay stable until rsp_valid&rsp_ready at an edge.
  - After that edge, go to IDLE with rsp_valid=0. No new request is accepted in that same edge.
  - Minimum request period is WAIT_STATES+2 cycles.
- Access check: the access is an error when any of these holds:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index addr>>2 >= DEPTH_WORDS (upper address bits are not ignored).
- On error: no memory change, rsp_err=1, rsp_rdata=0.
- Load:
  - Select the lane from addr[1:0] (byte lanes 0..3, half lanes 0 and 2).
  - Extend to 32 bits by the captured unsigned flag. Word loads are unmodified.
- Store:
  - Read-modify-write merge of the selected byte or half lane only; other lanes are preserved.
  - Word stores replace the whole word.
  - rsp_rdata=0, rsp_err=0.
- Request inputs are sampled only on the accept edge; changes while in WAIT or RESP are ignored.
- Reset in WAIT: the pending store is discarded (no commit), the memory is reinitialised and the FSM returns to IDLE.
- Reset in RESP: the response is dropped.
- Memory is single-ported: one access per transaction, and no read/write collision is possible.

Decomposition:
- Package dm_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the FSM state encoding IDLE/WAIT/RESP;
  - the address-to-word-index width function clog2(DEPTH_WORDS).
- Sub-module dm_lane_align is combinational. It takes addr[1:0], size, unsigned, the stored word and the store data, and produces:
  - the extended load value;
  - the merged store word;
  - the misalign flag.
- The top module holds the FSM, the counter, the array and the response registers.

Test Plan:
- Reset, then load word 0x10 with WAIT_STATES=2 -> rsp_valid 3 cycles after accept, rsp_rdata=0x00000004, rsp_err=0.
- Store byte 0xAB to 0x21, then load word 0x20 -> 0x0000AB08. Load byte 0x21 signed -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Store half 0x8001 to 0x22, then load half 0x22 signed -> 0xFFFF8001. Load word 0x20 -> 0x80010008.
- Load word 0x06; store word 0x400 (index 256); request with size=11 -> each gives rsp_err=1 and rsp_rdata=0. A following load of word 0x04 returns 0x00000001 (unchanged).
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 with req_valid=1 asserted; the request is accepted only after the response handshake plus the return to IDLE.
- Store word 0xDEADBEEF to 0x08, assert rst during WAIT -> after reset, load 0x08 returns 0x00000002 and rsp_valid is 0 throughout reset.
